seg_scan: RTL and testbench
===========================

Name: seg_scan

Overview:
- Time-multiplexed scan driver for a multi-digit common-cathode 7-segment display.
- Sits directly upstream of the SevenSEG decoder: its data_out and dp_out drive the decoder's data and dp inputs.
- Its dig_sel drives the digit cathode drivers.
- Latches a packed BCD value and decimal-point mask, then cycles through the digits at a fixed slot rate with optional leading-zero blanking and an anti-ghost blanking gap.

Parameters:
- DIGITS, 4: number of display digits (>=2).
- DIV, 50000: clock cycles per digit slot (>= BLANK_CYC+1).
- BLANK_CYC, 1: cycles at the start of each slot with all digits off (0 disables).
- BLANK_LZ, 1: 1 enables leading-zero blanking.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable.
- load  in  1  capture digits_in/dp_in into shadow registers.
- digits_in  in  4*DIGITS  packed digits; digit i = bits [4i+3:4i], digit 0 rightmost.
- dp_in  in  DIGITS  decimal-point mask, bit i for digit i.
- data_out  out  5  digit code to decoder; 5'h1F = blank.
- dp_out  out  1  decimal point to decoder.
- dig_sel  out  DIGITS  digit select, active low (0 sinks that digit's common cathode).

Behaviour:
- Interface: single clock clk; rst is synchronous and active-high. Reset has priority over load and en.
- Reset values:
  - shadow digits = 0, shadow dp = 0.
  - cnt = 0, idx = 0.
  - data_out = 5'd0, dp_out = 0, dig_sel = all ones.
- Shadow load:
  - On a cycle with load=1, the shadow registers take digits_in/dp_in at that edge. This applies regardless of en.
  - The new value appears on the outputs one cycle later (2-cycle load-to-output), provided that slot is active.
- Slot counter:
  - While en=1, cnt counts 0..DIV-1 and wraps.
  - When cnt==DIV-1, idx advances; idx DIGITS-1 wraps to 0.
  - Scan period = DIGITS*DIV cycles.
- en=0: cnt and idx are cleared to 0 next edge; dig_sel = all ones next edge; data_out/dp_out hold their last value.
  - On re-enable, the scan restarts at idx 0, cnt 0.
- Outputs are registered from (idx, cnt, shadow), one cycle behind the counters:
  - dig_sel: all ones if cnt < BLANK_CYC, otherwise only bit idx low.
  - data_out: the shadow digit at idx, zero-extended to 5 bits, or 5'h1F if that digit is blanked.
  - dp_out = shadow dp[idx]. The decimal point is shown even when the digit itself is blanked.
- Leading-zero blanking (BLANK_LZ=1):
  - Digit i (i>0) is blanked iff shadow digits i..DIGITS-1 are all zero.
  - Digit 0 is never blanked, so a value of all zeros shows a single "0".
  - BLANK_LZ=0 disables all blanking.
- Digit values 10..15 pass through unchanged; the decoder renders them off. This case is not an error.
- Load and slot wrap in the same cycle: both take effect; the next slot shows the new shadow value.
- Reset mid-slot: all state returns to reset values at that edge; an outstanding load in the same cycle is discarded.

Test Plan:
All scenarios use DIGITS=4, DIV=4, BLANK_CYC=1, BLANK_LZ=1 unless stated.
1. Reset: hold rst 2 cycles with en=1 and load=1 -> dig_sel=4'b1111, data_out=0, dp_out=0, shadow=0 after release.
2. Basic scan: load digits_in=16'h1234, dp_in=0, en=1.
   - Each slot: 1 cycle dig_sel=1111, then 3 cycles of the selected digit.
   - Sequence: dig_sel=1110/data_out=4, then 1101/3, then 1011/2, then 0111/1.
   - Wraps to idx 0 after 16 cycles.
3. Leading zeros:
   - digits_in=16'h0050 -> idx3 and idx2 data_out=5'h1F; idx1 shows 5; idx0 shows 0.
   - digits_in=16'h0000 -> only idx0 shows 0.
   - Repeat with BLANK_LZ=0 -> every digit shows 0.
4. dp on blanked digit: digits_in=16'h0007, dp_in=4'b0100 -> during the idx2 slot data_out=5'h1F and dp_out=1; dp_out=0 in all other slots.
5. Enable gating: drop en during the idx1 slot -> next edge dig_sel=1111; the counter holds at idx0/cnt0. Raise en -> one blank cycle, then dig_sel=1110.
6. Load/wrap collision: load 16'h9999 on the same cycle cnt==3 at idx0 -> the idx1 slot shows data_out=9. Then assert rst together with load=1 -> shadow stays 0 and outputs return to reset values.

Source files
------------

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed scan driver for a multi-digit common-cathode
// 7-segment display. Latches a packed BCD value plus decimal-point mask into
// shadow registers and walks through the digits one slot at a time, with
// optional leading-zero blanking and an all-off gap at the start of each slot.
//
// Control semantics (no handshake back-pressure on this block):
//   load - level-sampled each rising edge; when high the shadow registers
//          capture digits_in/dp_in at that edge, independent of en.
//   en   - while high the slot counter runs; when low the counters clear and
//          all digits are switched off on the next edge.
//   rst  - synchronous, highest priority; discards a simultaneous load.
module seg_scan #(
    parameter int DIGITS    = 4,
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 1,
    parameter int BLANK_LZ  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [4:0]            data_out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [4:0]    CODE_OFF  = 5'h1F;

    logic [4*DIGITS-1:0] shadow_dig;
    logic [DIGITS-1:0]   shadow_dp;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;

    logic [DIGITS-1:0]   blank;
    logic                zero_run;
    logic [3:0]          cur_dig;
    logic                cur_dp;
    logic                cur_blank;
    logic                in_gap;
    logic [4:0]          next_data;
    logic [DIGITS-1:0]   next_sel;

    // Shadow registers: capture the display value whenever load is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_dig <= '0;
            shadow_dp  <= '0;
        end else if (load) begin
            shadow_dig <= digits_in;
            shadow_dp  <= dp_in;
        end
    end

    // Slot counter and digit index; disabled scan restarts from digit 0.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Leading-zero mask: digit i>0 is blanked when it and every digit above
    // it are zero. Digit 0 is never blanked so an all-zero value shows "0".
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run & (shadow_dig[4*i +: 4] == 4'd0);
            blank[i] = (BLANK_LZ != 0) && zero_run;
        end
    end

    // Select the digit, dp bit and blank flag for the current index.
    always_comb begin
        cur_dig   = 4'd0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_dig   = shadow_dig[4*i +: 4];
                cur_dp    = shadow_dp[i];
                cur_blank = blank[i];
            end
        end
    end

    // Next output values: anti-ghost gap at slot start, otherwise one digit on.
    always_comb begin
        in_gap    = (BLANK_CYC != 0) && (cnt < BLANK_END);
        next_data = cur_blank ? CODE_OFF : {1'b0, cur_dig};
        next_sel  = in_gap ? '1 : ~(DIGITS'(1) << idx);
    end

    // Registered outputs, one cycle behind the counters. With en low the
    // digits are switched off but the last code/dp are held.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= 5'd0;
            dp_out   <= 1'b0;
            dig_sel  <= '1;
        end else if (!en) begin
            dig_sel  <= '1;
        end else begin
            data_out <= next_data;
            dp_out   <= cur_dp;
            dig_sel  <= next_sel;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed self-checking bench for seg_scan with DIGITS=4,
// DIV=4, BLANK_CYC=1. A second instance with leading-zero blanking disabled
// shares the same stimulus.
module tb_seg_scan;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [4:0]  data_out;
    logic        dp_out;
    logic [3:0]  dig_sel;
    logic [4:0]  data_out_n;
    logic        dp_out_n;
    logic [3:0]  dig_sel_n;

    int checks;
    int failures;

    logic [3:0] sel_tab [4];

    seg_scan #(.DIGITS(4), .DIV(4), .BLANK_CYC(1), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .digits_in(digits_in), .dp_in(dp_in),
        .data_out(data_out), .dp_out(dp_out), .dig_sel(dig_sel)
    );

    seg_scan #(.DIGITS(4), .DIV(4), .BLANK_CYC(1), .BLANK_LZ(0)) dut_nlz (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .digits_in(digits_in), .dp_in(dp_in),
        .data_out(data_out_n), .dp_out(dp_out_n), .dig_sel(dig_sel_n)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; load = 1'b1; digits_in = 16'hABCD; dp_in = 4'hF;
        step();
        step();
        checks++;
        if (dig_sel !== 4'b1111) begin failures++; $display("FAIL reset_sel got=%b exp=%b", dig_sel, 4'b1111); end
        checks++;
        if (data_out !== 5'd0) begin failures++; $display("FAIL reset_data got=%h exp=%h", data_out, 5'd0); end
        checks++;
        if (dp_out !== 1'b0) begin failures++; $display("FAIL reset_dp got=%b exp=%b", dp_out, 1'b0); end
        rst = 1'b0; load = 1'b0; en = 1'b0;
        step();
        checks++;
        if (dig_sel !== 4'b1111) begin failures++; $display("FAIL reset_idle_sel got=%b exp=%b", dig_sel, 4'b1111); end
        en = 1'b1;
        step();
        checks++;
        if (dig_sel !== 4'b1111) begin failures++; $display("FAIL reset_gap_sel got=%b exp=%b", dig_sel, 4'b1111); end
        step();
        checks++;
        if (dig_sel !== 4'b1110) begin failures++; $display("FAIL reset_shadow_sel got=%b exp=%b", dig_sel, 4'b1110); end
        checks++;
        if (data_out !== 5'd0) begin failures++; $display("FAIL reset_shadow_data got=%h exp=%h", data_out, 5'd0); end
        checks++;
        if (dp_out !== 1'b0) begin failures++; $display("FAIL reset_shadow_dp got=%b exp=%b", dp_out, 1'b0); end
        en = 1'b0;
        step();
    endtask

    task automatic test_basic_scan();
        logic [4:0] exp_d [4];
        logic [3:0] exp_s;
        int i, c;
        exp_d = '{5'd4, 5'd3, 5'd2, 5'd1};
        load = 1'b1; digits_in = 16'h1234; dp_in = 4'b0000; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            i = ((k - 1) / 4) % 4;
            c = (k - 1) % 4;
            exp_s = (c == 0) ? 4'b1111 : sel_tab[i];
            checks++;
            if (dig_sel !== exp_s) begin failures++; $display("FAIL basic_sel k=%0d got=%b exp=%b", k, dig_sel, exp_s); end
            checks++;
            if (data_out !== exp_d[i]) begin failures++; $display("FAIL basic_data k=%0d got=%h exp=%h", k, data_out, exp_d[i]); end
            checks++;
            if (dp_out !== 1'b0) begin failures++; $display("FAIL basic_dp k=%0d got=%b exp=%b", k, dp_out, 1'b0); end
        end
        en = 1'b0;
        step();
    endtask

    task automatic test_leading_zero();
        logic [15:0] pat [2];
        logic [4:0]  exp_lz [2][4];
        logic [4:0]  exp_n  [2][4];
        int i;
        pat       = '{16'h0050, 16'h0000};
        exp_lz[0] = '{5'd0, 5'd5, 5'h1F, 5'h1F};
        exp_n[0]  = '{5'd0, 5'd5, 5'd0, 5'd0};
        exp_lz[1] = '{5'd0, 5'h1F, 5'h1F, 5'h1F};
        exp_n[1]  = '{5'd0, 5'd0, 5'd0, 5'd0};
        for (int p = 0; p < 2; p++) begin
            load = 1'b1; digits_in = pat[p]; dp_in = 4'b0000; en = 1'b0;
            step();
            load = 1'b0; en = 1'b1;
            for (int k = 1; k <= 16; k++) begin
                step();
                i = ((k - 1) / 4) % 4;
                checks++;
                if (data_out !== exp_lz[p][i]) begin
                    failures++;
                    $display("FAIL lz_data pat=%h k=%0d got=%h exp=%h", pat[p], k, data_out, exp_lz[p][i]);
                end
                checks++;
                if (data_out_n !== exp_n[p][i]) begin
                    failures++;
                    $display("FAIL nolz_data pat=%h k=%0d got=%h exp=%h", pat[p], k, data_out_n, exp_n[p][i]);
                end
            end
            en = 1'b0;
            step();
        end
    endtask

    task automatic test_dp_blanked();
        logic [4:0] exp_d [4];
        logic       exp_p [4];
        int i;
        exp_d = '{5'd7, 5'h1F, 5'h1F, 5'h1F};
        exp_p = '{1'b0, 1'b0, 1'b1, 1'b0};
        load = 1'b1; digits_in = 16'h0007; dp_in = 4'b0100; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            i = ((k - 1) / 4) % 4;
            checks++;
            if (data_out !== exp_d[i]) begin failures++; $display("FAIL dp_data k=%0d got=%h exp=%h", k, data_out, exp_d[i]); end
            checks++;
            if (dp_out !== exp_p[i]) begin failures++; $display("FAIL dp_out k=%0d got=%b exp=%b", k, dp_out, exp_p[i]); end
        end
        en = 1'b0;
        step();
    endtask

    task automatic test_enable_gating();
        load = 1'b1; digits_in = 16'h1234; dp_in = 4'b0000; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1;
        for (int k = 1; k <= 6; k++) step();
        checks++;
        if (dig_sel !== 4'b1101) begin failures++; $display("FAIL en_pre_sel got=%b exp=%b", dig_sel, 4'b1101); end
        en = 1'b0;
        step();
        checks++;
        if (dig_sel !== 4'b1111) begin failures++; $display("FAIL en_off_sel got=%b exp=%b", dig_sel, 4'b1111); end
        checks++;
        if (data_out !== 5'd3) begin failures++; $display("FAIL en_off_hold got=%h exp=%h", data_out, 5'd3); end
        step();
        checks++;
        if (dig_sel !== 4'b1111) begin failures++; $display("FAIL en_off2_sel got=%b exp=%b", dig_sel, 4'b1111); end
        en = 1'b1;
        step();
        checks++;
        if (dig_sel !== 4'b1111) begin failures++; $display("FAIL en_gap_sel got=%b exp=%b", dig_sel, 4'b1111); end
        checks++;
        if (data_out !== 5'd4) begin failures++; $display("FAIL en_gap_data got=%h exp=%h", data_out, 5'd4); end
        step();
        checks++;
        if (dig_sel !== 4'b1110) begin failures++; $display("FAIL en_restart_sel got=%b exp=%b", dig_sel, 4'b1110); end
        checks++;
        if (data_out !== 5'd4) begin failures++; $display("FAIL en_restart_data got=%h exp=%h", data_out, 5'd4); end
        en = 1'b0;
        step();
    endtask

    task automatic test_collision();
        load = 1'b1; digits_in = 16'h1234; dp_in = 4'b0000; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1;
        for (int k = 1; k <= 3; k++) step();
        load = 1'b1; digits_in = 16'h9999;
        step();
        checks++;
        if (dig_sel !== 4'b1110) begin failures++; $display("FAIL coll_last_sel got=%b exp=%b", dig_sel, 4'b1110); end
        checks++;
        if (data_out !== 5'd4) begin failures++; $display("FAIL coll_last_data got=%h exp=%h", data_out, 5'd4); end
        load = 1'b0;
        step();
        checks++;
        if (dig_sel !== 4'b1111) begin failures++; $display("FAIL coll_gap_sel got=%b exp=%b", dig_sel, 4'b1111); end
        step();
        checks++;
        if (dig_sel !== 4'b1101) begin failures++; $display("FAIL coll_new_sel got=%b exp=%b", dig_sel, 4'b1101); end
        checks++;
        if (data_out !== 5'd9) begin failures++; $display("FAIL coll_new_data got=%h exp=%h", data_out, 5'd9); end
        // Reset together with load: the load must be discarded.
        rst = 1'b1; load = 1'b1; digits_in = 16'h5678; dp_in = 4'hF;
        step();
        checks++;
        if (dig_sel !== 4'b1111) begin failures++; $display("FAIL rstload_sel got=%b exp=%b", dig_sel, 4'b1111); end
        checks++;
        if (data_out !== 5'd0) begin failures++; $display("FAIL rstload_data got=%h exp=%h", data_out, 5'd0); end
        checks++;
        if (dp_out !== 1'b0) begin failures++; $display("FAIL rstload_dp got=%b exp=%b", dp_out, 1'b0); end
        rst = 1'b0; load = 1'b0;
        step();
        step();
        checks++;
        if (dig_sel !== 4'b1110) begin failures++; $display("FAIL rstload_scan_sel got=%b exp=%b", dig_sel, 4'b1110); end
        checks++;
        if (data_out !== 5'd0) begin failures++; $display("FAIL rstload_scan_data got=%h exp=%h", data_out, 5'd0); end
        checks++;
        if (dp_out !== 1'b0) begin failures++; $display("FAIL rstload_scan_dp got=%b exp=%b", dp_out, 1'b0); end
        step();
        step();
        step();
        checks++;
        if (data_out !== 5'h1F) begin failures++; $display("FAIL rstload_idx1_data got=%h exp=%h", data_out, 5'h1F); end
        en = 1'b0;
        step();
    endtask

    // Test sequence and final report
    initial begin
        checks = 0;
        failures = 0;
        sel_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        rst = 1'b1; en = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0;
        test_reset();
        test_basic_scan();
        test_leading_zero();
        test_dp_blanked();
        test_enable_gating();
        test_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
